video_sig_gen: RTL and testbench

//  Free-running 720p video timing generator; sits directly upstream of the renderer.

---
 rtl/video_sig_gen.sv | 84 ++++++++
 tb/tb_video_sig_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_sig_gen.sv
// 720p video timing generator: free-running h/v counters with registered, aligned sync/draw/frame flags.
// Optional line-start pulse output ls_out is enabled by defining VSG_LINE_PULSE_EN.
module video_sig_gen #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNC_WIDTH    = 40,
  parameter int H_BACK_PORCH    = 220,
  parameter int ACTIVE_LINES    = 720,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNC_WIDTH    = 5,
  parameter int V_BACK_PORCH    = 20,
  parameter int FPS             = 60,
  localparam int H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
  localparam int V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL),
  localparam int FW = $clog2(FPS)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  output logic [HW-1:0] hcount_out,
  output logic [VW-1:0] vcount_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          ad_out,
  output logic          nf_out,
  output logic [FW-1:0] fc_out
`ifdef VSG_LINE_PULSE_EN
  ,
  output logic          ls_out
`endif
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(ACTIVE_H_PIXELS);
  localparam logic [VW-1:0] V_ACT    = VW'(ACTIVE_LINES);
  localparam logic [HW-1:0] HS_START = HW'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [HW-1:0] HS_END   = HW'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [VW-1:0] VS_START = VW'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [VW-1:0] VS_END   = VW'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);
  localparam logic [FW-1:0] FC_LAST  = FW'(FPS - 1);

  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          nf_next;

  // Flags are derived from the next counter values so they line up with the registered counters.
  always_comb begin
    h_next = (hcount_out == H_LAST) ? '0 : hcount_out + HW'(1);
    v_next = vcount_out;
    if (hcount_out == H_LAST)
      v_next = (vcount_out == V_LAST) ? '0 : vcount_out + VW'(1);
    nf_next = (h_next == H_ACT) && (v_next == V_ACT);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hcount_out <= H_LAST;
      vcount_out <= V_LAST;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      ad_out     <= 1'b0;
      nf_out     <= 1'b0;
      fc_out     <= '0;
`ifdef VSG_LINE_PULSE_EN
      ls_out     <= 1'b0;
`endif
    end else begin
      hcount_out <= h_next;
      vcount_out <= v_next;
      hs_out     <= (h_next >= HS_START) && (h_next < HS_END);
      vs_out     <= (v_next >= VS_START) && (v_next < VS_END);
      ad_out     <= (h_next < H_ACT) && (v_next < V_ACT);
      nf_out     <= nf_next;
      if (nf_next)
        fc_out <= (fc_out == FC_LAST) ? '0 : fc_out + FW'(1);
`ifdef VSG_LINE_PULSE_EN
      ls_out     <= (h_next == '0) && (v_next < V_ACT);
`endif
    end
  end

endmodule

// File: tb/tb_video_sig_gen.sv
// Bench for video_sig_gen: a full 720p instance for reset/line checks and a shrunken instance
// (16x10 pixels, FPS 5) for frame, sync and frame-counter checks within a short run.
module tb_video_sig_gen;

  logic clk;
  logic f_rst, s_rst;

  logic [10:0] f_h;
  logic [9:0]  f_v;
  logic        f_hs, f_vs, f_ad, f_nf;
  logic [5:0]  f_fc;

  logic [3:0]  s_h;
  logic [3:0]  s_v;
  logic        s_hs, s_vs, s_ad, s_nf;
  logic [2:0]  s_fc;

`ifdef VSG_LINE_PULSE_EN
  logic f_ls, s_ls;
`endif

  int tests = 0;
  int fails = 0;

  video_sig_gen u_full (
    .clk_in(clk), .rst_in(f_rst),
    .hcount_out(f_h), .vcount_out(f_v),
    .hs_out(f_hs), .vs_out(f_vs), .ad_out(f_ad), .nf_out(f_nf), .fc_out(f_fc)
`ifdef VSG_LINE_PULSE_EN
    , .ls_out(f_ls)
`endif
  );

  // H: 8 active, 2 fp, 3 sync (10..12), 3 bp -> 16; V: 6 active, 1 fp, 2 sync (7..8), 1 bp -> 10
  video_sig_gen #(
    .ACTIVE_H_PIXELS(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(3),
    .ACTIVE_LINES(6), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(1),
    .FPS(5)
  ) u_small (
    .clk_in(clk), .rst_in(s_rst),
    .hcount_out(s_h), .vcount_out(s_v),
    .hs_out(s_hs), .vs_out(s_vs), .ad_out(s_ad), .nf_out(s_nf), .fc_out(s_fc)
`ifdef VSG_LINE_PULSE_EN
    , .ls_out(s_ls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_s_nf(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (s_nf) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    f_rst = 1'b1;
    s_rst = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (f_h !== 11'd1649 || f_v !== 10'd749) begin
      fails++; $display("FAIL reset_pos: got (%0d,%0d) expected (1649,749)", f_h, f_v);
    end
    tests++;
    if ({f_hs, f_vs, f_ad, f_nf} !== 4'b0000 || f_fc !== 6'd0) begin
      fails++; $display("FAIL reset_flags: got hs/vs/ad/nf=%b fc=%0d expected 0000 fc=0",
                        {f_hs, f_vs, f_ad, f_nf}, f_fc);
    end
    tests++;
    if (s_h !== 4'd15 || s_v !== 4'd9) begin
      fails++; $display("FAIL reset_pos_small: got (%0d,%0d) expected (15,9)", s_h, s_v);
    end
    f_rst = 1'b0;
    s_rst = 1'b0;
    @(negedge clk);
    tests++;
    if (f_h !== 11'd0 || f_v !== 10'd0) begin
      fails++; $display("FAIL first_pos: got (%0d,%0d) expected (0,0)", f_h, f_v);
    end
    tests++;
    if ({f_hs, f_vs, f_ad, f_nf} !== 4'b0010 || f_fc !== 6'd0) begin
      fails++; $display("FAIL first_flags: got hs/vs/ad/nf=%b fc=%0d expected 0010 fc=0",
                        {f_hs, f_vs, f_ad, f_nf}, f_fc);
    end
    tests++;
    if (s_h !== 4'd0 || s_v !== 4'd0 || s_ad !== 1'b1) begin
      fails++; $display("FAIL first_small: got (%0d,%0d) ad=%b expected (0,0) ad=1", s_h, s_v, s_ad);
    end
  endtask

  task automatic test_line;
    int pos_err = 0, ad_cnt = 0, ad_rise = 0, hs_cnt = 0, hs_rise = 0, hs_first = -1;
    logic ad_prev = 1'b0, hs_prev = 1'b0;
    for (int i = 0; i < 1650; i++) begin
      if (f_h !== 11'(i) || f_v !== 10'd0) pos_err++;
      if (f_ad) ad_cnt++;
      if (f_ad && !ad_prev) ad_rise++;
      if (f_hs) hs_cnt++;
      if (f_hs && !hs_prev) begin
        hs_rise++;
        if (hs_first < 0) hs_first = int'(f_h);
      end
      ad_prev = f_ad;
      hs_prev = f_hs;
      @(negedge clk);
    end
    tests++;
    if (pos_err != 0) begin
      fails++; $display("FAIL line_hcount: got %0d position errors expected 0", pos_err);
    end
    tests++;
    if (ad_cnt != 1280 || ad_rise != 1) begin
      fails++; $display("FAIL line_ad: got %0d cycles in %0d runs expected 1280 in 1", ad_cnt, ad_rise);
    end
    tests++;
    if (hs_cnt != 40 || hs_rise != 1 || hs_first != 1390) begin
      fails++; $display("FAIL line_hs: got %0d cycles %0d runs start %0d expected 40 1 1390",
                        hs_cnt, hs_rise, hs_first);
    end
    tests++;
    if (f_h !== 11'd0 || f_v !== 10'd1) begin
      fails++; $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", f_h, f_v);
    end
  endtask

  task automatic test_mid_reset_full;
    bit found = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (f_h == 11'd500) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL midrst_reach: got h=%0d expected h=500 within budget", f_h);
    end
    f_rst = 1'b1;
    @(negedge clk);
    f_rst = 1'b0;
    tests++;
    if (f_h !== 11'd1649 || f_v !== 10'd749 || {f_hs, f_vs, f_ad, f_nf} !== 4'b0000 || f_fc !== 6'd0) begin
      fails++; $display("FAIL midrst_full: got (%0d,%0d) flags=%b fc=%0d expected (1649,749) 0000 0",
                        f_h, f_v, {f_hs, f_vs, f_ad, f_nf}, f_fc);
    end
    @(negedge clk);
    tests++;
    if (f_h !== 11'd0 || f_v !== 10'd0 || f_ad !== 1'b1) begin
      fails++; $display("FAIL midrst_full_after: got (%0d,%0d) ad=%b expected (0,0) ad=1", f_h, f_v, f_ad);
    end
  endtask

  task automatic test_frame;
    bit ok;
    logic [3:0] eh, ev;
    logic [2:0] fc0, fc_exp;
    int pos_err = 0, flag_err = 0, ad_cnt = 0, hs_cnt = 0, vs_cnt = 0, nf_cnt = 0, ls_cnt = 0;
    int vs_fh = -1, vs_fv = -1;
    wait_s_nf(400, ok);
    tests++;
    if (!ok || s_h !== 4'd8 || s_v !== 4'd6) begin
      fails++; $display("FAIL frame_nf_pos: got ok=%0d (%0d,%0d) expected 1 (8,6)", ok, s_h, s_v);
    end
    fc0 = s_fc;
    fc_exp = (fc0 == 3'd4) ? 3'd0 : fc0 + 3'd1;
    eh = 4'd8;
    ev = 4'd6;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (eh == 4'd15) begin
        eh = 4'd0;
        ev = (ev == 4'd9) ? 4'd0 : ev + 4'd1;
      end else begin
        eh = eh + 4'd1;
      end
      if (s_h !== eh || s_v !== ev) pos_err++;
      if (s_hs !== (eh >= 4'd10 && eh <= 4'd12)) flag_err++;
      if (s_vs !== (ev == 4'd7 || ev == 4'd8)) flag_err++;
      if (s_ad !== (eh < 4'd8 && ev < 4'd6)) flag_err++;
`ifdef VSG_LINE_PULSE_EN
      if (s_ls !== (eh == 4'd0 && ev < 4'd6)) flag_err++;
      if (s_ls) ls_cnt++;
`endif
      if (s_ad) ad_cnt++;
      if (s_hs) hs_cnt++;
      if (s_nf) nf_cnt++;
      if (s_vs) begin
        vs_cnt++;
        if (vs_fh < 0) begin
          vs_fh = int'(s_h);
          vs_fv = int'(s_v);
        end
      end
    end
    tests++;
    if (pos_err != 0) begin
      fails++; $display("FAIL frame_pos: got %0d position errors expected 0", pos_err);
    end
    tests++;
    if (flag_err != 0) begin
      fails++; $display("FAIL frame_flags: got %0d flag errors expected 0", flag_err);
    end
    tests++;
    if (ad_cnt != 48 || hs_cnt != 30 || vs_cnt != 32) begin
      fails++; $display("FAIL frame_counts: got ad=%0d hs=%0d vs=%0d expected 48 30 32", ad_cnt, hs_cnt, vs_cnt);
    end
    tests++;
    if (vs_fh != 0 || vs_fv != 7) begin
      fails++; $display("FAIL frame_vs_start: got (%0d,%0d) expected (0,7)", vs_fh, vs_fv);
    end
    tests++;
    if (nf_cnt != 1 || s_nf !== 1'b1 || s_h !== 4'd8 || s_v !== 4'd6) begin
      fails++; $display("FAIL frame_nf_period: got %0d pulses nf=%b at (%0d,%0d) expected 1 1 (8,6)",
                        nf_cnt, s_nf, s_h, s_v);
    end
    tests++;
    if (s_fc !== fc_exp) begin
      fails++; $display("FAIL frame_fc: got %0d expected %0d", s_fc, fc_exp);
    end
`ifdef VSG_LINE_PULSE_EN
    tests++;
    if (ls_cnt != 6) begin
      fails++; $display("FAIL frame_ls: got %0d pulses expected 6", ls_cnt);
    end
`endif
  endtask

  task automatic test_fc_wrap;
    bit ok;
    logic [2:0] exp_fc [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    s_rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    tests++;
    if (s_fc !== 3'd0 || s_nf !== 1'b0) begin
      fails++; $display("FAIL fc_reset: got fc=%0d nf=%b expected 0 0", s_fc, s_nf);
    end
    for (int k = 0; k < 6; k++) begin
      wait_s_nf(200, ok);
      tests++;
      if (!ok || s_fc !== exp_fc[k]) begin
        fails++; $display("FAIL fc_seq%0d: got ok=%0d fc=%0d expected 1 %0d", k, ok, s_fc, exp_fc[k]);
      end
      @(negedge clk);
      if (k == 0) begin
        tests++;
        if (s_nf !== 1'b0) begin
          fails++; $display("FAIL nf_width: got nf=%b one cycle later expected 0", s_nf);
        end
      end
    end
  endtask

  task automatic test_mid_reset_small;
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (s_h == 4'd11 && s_v == 4'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!found || s_hs !== 1'b1 || s_vs !== 1'b1) begin
      fails++; $display("FAIL midrst_small_pre: got found=%0d hs=%b vs=%b expected 1 1 1", found, s_hs, s_vs);
    end
    s_rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    tests++;
    if (s_h !== 4'd15 || s_v !== 4'd9 || {s_hs, s_vs, s_ad, s_nf} !== 4'b0000 || s_fc !== 3'd0) begin
      fails++; $display("FAIL midrst_small: got (%0d,%0d) flags=%b fc=%0d expected (15,9) 0000 0",
                        s_h, s_v, {s_hs, s_vs, s_ad, s_nf}, s_fc);
    end
`ifdef VSG_LINE_PULSE_EN
    tests++;
    if (s_ls !== 1'b0) begin
      fails++; $display("FAIL midrst_ls: got %b expected 0", s_ls);
    end
`endif
    @(negedge clk);
    tests++;
    if (s_h !== 4'd0 || s_v !== 4'd0 || s_ad !== 1'b1 || s_fc !== 3'd0) begin
      fails++; $display("FAIL midrst_small_after: got (%0d,%0d) ad=%b fc=%0d expected (0,0) 1 0",
                        s_h, s_v, s_ad, s_fc);
    end
  endtask

  initial begin
    f_rst = 1'b1;
    s_rst = 1'b1;
    test_reset();
    test_line();
    test_mid_reset_full();
    test_frame();
    test_fc_wrap();
    test_mid_reset_small();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
